// File: rtl/ifmap_gin_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_gin_dispatcher
// Purpose  : Pops GIN data/tag pairs and multicasts each word to matching PEs.
// Revision : 1.0
// ============================================================================
module ifmap_gin_dispatcher #(
    parameter int DATA_WIDTH    = 16,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 5,
    parameter int NUM_ROWS      = 12,
    parameter int NUM_COLS      = 14,
    parameter int COUNT_WIDTH   = 20
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [COUNT_WIDTH-1:0]                     total_words,
    output logic                                       busy,
    output logic                                       done,
    input  logic                                       gin_fifo_empty,
    output logic                                       re_from_gin_fifo,
    input  logic [DATA_WIDTH-1:0]                      gin_fifo_dout,
    input  logic                                       tags_fifo_empty,
    output logic                                       re_from_tags_fifo,
    input  logic [ROW_TAG_WIDTH-1:0]                   row_tag_in,
    input  logic [COL_TAG_WIDTH-1:0]                   col_tag_in,
    input  logic [NUM_ROWS*ROW_TAG_WIDTH-1:0]          row_id_cfg,
    input  logic [NUM_ROWS*NUM_COLS*COL_TAG_WIDTH-1:0] col_id_cfg,
    input  logic [NUM_ROWS*NUM_COLS-1:0]               pe_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]               pe_we,
    output logic [DATA_WIDTH-1:0]                      bus_data,
    output logic [COUNT_WIDTH-1:0]                     drop_count
);

    localparam int NUM_PES = NUM_ROWS * NUM_COLS;
    localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DECIDE  = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0]  drop_q, drop_d;
    logic [DATA_WIDTH-1:0]   bus_q, bus_d;
    logic [NUM_PES-1:0]      mask_q, mask_d;

    logic [NUM_PES-1:0]      match;
    logic                    re_pair;
    logic                    word_done;
    logic [NUM_PES-1:0]      we;

    // Tag match per PE: row ID compared once per row, column ID per PE.
    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            logic row_hit;
            assign row_hit = (row_id_cfg[i*ROW_TAG_WIDTH +: ROW_TAG_WIDTH] == row_tag_in);
            for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
                assign match[i*NUM_COLS+j] = row_hit &&
                    (col_id_cfg[(i*NUM_COLS+j)*COL_TAG_WIDTH +: COL_TAG_WIDTH] == col_tag_in);
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        drop_d      = drop_q;
        bus_d       = bus_q;
        mask_d      = mask_q;
        re_pair     = 1'b0;
        word_done   = 1'b0;
        we          = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = total_words;
                    drop_d      = '0;
                    if (total_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!gin_fifo_empty && !tags_fifo_empty) begin
                    re_pair = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                bus_d   = gin_fifo_dout;
                mask_d  = match;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (mask_q == '0) begin
                    if (drop_q != C_CNT_MAX) begin
                        drop_d = drop_q + C_CNT_ONE;
                    end
                    word_done = 1'b1;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // All-or-nothing: never write to a subset of the mask.
                if ((pe_ready & mask_q) == mask_q) begin
                    we        = mask_q;
                    word_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (word_done) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - C_CNT_ONE;
            end
            if (remaining_q <= C_CNT_ONE) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            drop_q      <= '0;
            bus_q       <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            drop_q      <= drop_d;
            bus_q       <= bus_d;
            mask_q      <= mask_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign re_from_gin_fifo  = re_pair;
    assign re_from_tags_fifo = re_pair;
    assign pe_we             = we;
    assign bus_data          = bus_q;
    assign drop_count        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ifmap_gin_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifmap_gin_dispatcher
// Purpose  : Directed self-checking bench for ifmap_gin_dispatcher.
// Revision : 1.0
// ============================================================================
module tb_ifmap_gin_dispatcher;

    localparam int DW  = 16;
    localparam int RTW = 4;
    localparam int CTW = 5;
    localparam int NR  = 12;
    localparam int NC  = 14;
    localparam int CW  = 20;
    localparam int NP  = NR * NC;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [CW-1:0]         total_words = '0;
    logic                  busy, done;
    logic                  gin_fifo_empty = 1'b1;
    logic                  re_from_gin_fifo;
    logic [DW-1:0]         gin_fifo_dout = '0;
    logic                  tags_fifo_empty = 1'b1;
    logic                  re_from_tags_fifo;
    logic [RTW-1:0]        row_tag_in = '0;
    logic [CTW-1:0]        col_tag_in = '0;
    logic [NR*RTW-1:0]     row_id_cfg = '0;
    logic [NP*CTW-1:0]     col_id_cfg = '0;
    logic [NP-1:0]         pe_ready = '0;
    logic [NP-1:0]         pe_we;
    logic [DW-1:0]         bus_data;
    logic [CW-1:0]         drop_count;

    ifmap_gin_dispatcher #(
        .DATA_WIDTH(DW), .ROW_TAG_WIDTH(RTW), .COL_TAG_WIDTH(CTW),
        .NUM_ROWS(NR), .NUM_COLS(NC), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .total_words(total_words),
        .busy(busy), .done(done),
        .gin_fifo_empty(gin_fifo_empty), .re_from_gin_fifo(re_from_gin_fifo),
        .gin_fifo_dout(gin_fifo_dout),
        .tags_fifo_empty(tags_fifo_empty), .re_from_tags_fifo(re_from_tags_fifo),
        .row_tag_in(row_tag_in), .col_tag_in(col_tag_in),
        .row_id_cfg(row_id_cfg), .col_id_cfg(col_id_cfg),
        .pe_ready(pe_ready), .pe_we(pe_we), .bus_data(bus_data),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO models; empty flags follow queue occupancy.
    logic [DW-1:0]        gq[$];
    logic [RTW+CTW-1:0]   tq[$];
    int gin_reads = 0, tags_reads = 0, split_reads = 0, underflows = 0;

    always @(posedge clk) begin
        if (re_from_gin_fifo != re_from_tags_fifo) split_reads++;
        if (re_from_gin_fifo) begin
            gin_reads++;
            if (gq.size() == 0) underflows++;
            else gin_fifo_dout <= gq.pop_front();
        end
        if (re_from_tags_fifo) begin
            tags_reads++;
            if (tq.size() == 0) underflows++;
            else {row_tag_in, col_tag_in} <= tq.pop_front();
        end
        gin_fifo_empty  <= (gq.size() == 0);
        tags_fifo_empty <= (tq.size() == 0);
    end

    // Output monitor, sampled mid-cycle.
    int cyc = 0, we_count = 0, done_count = 0, busy_cycles = 0, bad_we = 0;
    int start_cyc = 0, we_cyc = 0, done_cyc = 0;
    logic [NP-1:0] last_we = '0;
    logic [DW-1:0] last_bus = '0;
    logic          busy_at_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (start && !busy) start_cyc = cyc;
        if (busy) busy_cycles++;
        if (pe_we != '0) begin
            we_count++;
            we_cyc   = cyc;
            last_we  = pe_we;
            last_bus = bus_data;
            if ((pe_we & ~pe_ready) != '0) bad_we++;
        end
        if (done) begin
            done_count++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = done_count;
        int k = 0;
        while (done_count == base && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 256'(done_count != base), 256'(1));
    endtask

    task automatic set_ids(input bit multicast);
        for (int i = 0; i < NR; i++) begin
            row_id_cfg[i*RTW +: RTW] = (multicast && i < 3) ? 4'd0 : 4'(i);
            for (int j = 0; j < NC; j++)
                col_id_cfg[(i*NC+j)*CTW +: CTW] = 5'(j);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input int r, input int c);
        gq.push_back(d);
        tq.push_back({4'(r), 5'(c)});
    endtask

    task automatic run_pass(input int n);
        tick(2);
        total_words = CW'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [NP-1:0] bit_at(input int r, input int c);
        logic [NP-1:0] m = '0;
        m[r*NC+c] = 1'b1;
        return m;
    endfunction

    initial begin
        int b_we, b_done, b_gr, b_tr, b_busy;

        tick(3);
        reset = 1'b0;
        chk("rst_busy", 256'(busy), 0);
        chk("rst_done", 256'(done), 0);
        chk("rst_we", 256'(pe_we), 0);
        chk("rst_bus", 256'(bus_data), 0);
        chk("rst_drop", 256'(drop_count), 0);
        chk("rst_re", 256'({re_from_gin_fifo, re_from_tags_fifo}), 0);

        // Single word to PE(2,5).
        set_ids(1'b0);
        pe_ready = '1;
        b_we = we_count;
        push(16'h00AB, 2, 5);
        run_pass(1);
        wait_done("t1_done", 40);
        chk("t1_we_cnt", 256'(we_count - b_we), 1);
        chk("t1_we_mask", 256'(last_we), 256'(bit_at(2, 5)));
        chk("t1_bus", 256'(last_bus), 256'h00AB);
        chk("t1_latency", 256'(we_cyc - start_cyc), 4);
        chk("t1_done_lag", 256'(done_cyc - we_cyc), 1);
        chk("t1_busy_at_done", 256'(busy_at_done), 0);
        chk("t1_drop", 256'(drop_count), 0);

        // Multicast to column 3 of rows 0..2, PE(1,3) late.
        set_ids(1'b1);
        pe_ready = '1;
        pe_ready[1*NC+3] = 1'b0;
        b_we = we_count;
        push(16'h1234, 0, 3);
        run_pass(1);
        tick(8);
        chk("t2_no_partial", 256'(we_count - b_we), 0);
        pe_ready[1*NC+3] = 1'b1;
        wait_done("t2_done", 40);
        chk("t2_we_cnt", 256'(we_count - b_we), 1);
        chk("t2_we_mask", 256'(last_we), 256'(bit_at(0, 3) | bit_at(1, 3) | bit_at(2, 3)));
        chk("t2_bus", 256'(last_bus), 256'h1234);

        // Middle word of three matches nobody.
        set_ids(1'b0);
        b_we = we_count; b_gr = gin_reads; b_tr = tags_reads; b_done = done_count;
        push(16'h0101, 4, 6);
        push(16'h0202, 15, 0);
        push(16'h0303, 11, 13);
        run_pass(3);
        wait_done("t3_done", 80);
        chk("t3_we_cnt", 256'(we_count - b_we), 2);
        chk("t3_drop", 256'(drop_count), 1);
        chk("t3_last_mask", 256'(last_we), 256'(bit_at(11, 13)));
        chk("t3_last_bus", 256'(last_bus), 256'h0303);
        chk("t3_gin_reads", 256'(gin_reads - b_gr), 3);
        chk("t3_tag_reads", 256'(tags_reads - b_tr), 3);
        chk("t3_done_cnt", 256'(done_count - b_done), 1);

        // Tags FIFO empty: no reads until both sides have data.
        b_gr = gin_reads; b_tr = tags_reads;
        gq.push_back(16'h0404);
        run_pass(1);
        tick(4);
        chk("t4_stall_gin", 256'(gin_reads - b_gr), 0);
        chk("t4_stall_tags", 256'(tags_reads - b_tr), 0);
        tq.push_back({4'd3, 5'd3});
        wait_done("t4_done", 40);
        chk("t4_gin_reads", 256'(gin_reads - b_gr), 1);
        chk("t4_tag_reads", 256'(tags_reads - b_tr), 1);
        chk("t4_bus", 256'(last_bus), 256'h0404);
        chk("t4_mask", 256'(last_we), 256'(bit_at(3, 3)));

        // Zero-length pass.
        b_busy = busy_cycles; b_gr = gin_reads; b_done = done_count;
        tick(2);
        total_words = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t5_done", 256'(done), 1);
        chk("t5_busy", 256'(busy), 0);
        tick(1);
        chk("t5_done_pulse", 256'(done), 0);
        chk("t5_busy_cycles", 256'(busy_cycles - b_busy), 0);
        chk("t5_reads", 256'(gin_reads - b_gr), 0);
        chk("t5_done_cnt", 256'(done_count - b_done), 1);

        // Reset while waiting in SEND, then a clean two-word pass.
        pe_ready = '0;
        b_we = we_count; b_done = done_count;
        push(16'h0505, 2, 5);
        run_pass(1);
        tick(7);
        chk("t6_waiting", 256'(we_count - b_we), 0);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_busy", 256'(busy), 0);
        chk("t6_rst_done", 256'(done), 0);
        chk("t6_rst_we", 256'(pe_we), 0);
        chk("t6_rst_bus", 256'(bus_data), 0);
        chk("t6_rst_drop", 256'(drop_count), 0);
        chk("t6_rst_re", 256'({re_from_gin_fifo, re_from_tags_fifo}), 0);
        reset = 1'b0;
        pe_ready = '1;
        push(16'h0606, 2, 5);
        push(16'h0707, 4, 6);
        run_pass(2);
        wait_done("t6_done", 60);
        chk("t6_we_cnt", 256'(we_count - b_we), 2);
        chk("t6_done_cnt", 256'(done_count - b_done), 1);
        chk("t6_last_bus", 256'(last_bus), 256'h0707);

        tick(2);
        chk("no_split_reads", 256'(split_reads), 0);
        chk("no_underflow", 256'(underflows), 0);
        chk("no_unready_we", 256'(bad_we), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
